// File: rtl/hv_alu_pkg.sv
// Shared types and default widths for the iterative hypervector ALU PE.
package hv_alu_pkg;

    localparam int HV_DIM_DEFAULT     = 512;
    localparam int NUM_OPS_DEFAULT    = 8;
    localparam int MAX_SHIFT_DEFAULT  = 128;
    localparam int MAX_REPEAT_DEFAULT = 15;

    // ALU operation codes; any code above HV_PASSB behaves as XOR
    typedef enum logic [2:0] {
        HV_XOR   = 3'd0,
        HV_AND   = 3'd1,
        HV_OR    = 3'd2,
        HV_ROR   = 3'd3,
        HV_ROL   = 3'd4,
        HV_NOT   = 3'd5,
        HV_PASSA = 3'd6,
        HV_PASSB = 3'd7
    } hv_op_e;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } hv_state_e;

endpackage

// File: rtl/hv_alu_step.sv
// Single-iteration combinational hypervector datapath: result = f(acc, b).
// The rotate amount s must already be reduced modulo HVDimension.
module hv_alu_step
    import hv_alu_pkg::*;
#(
    parameter int HVDimension  = HV_DIM_DEFAULT,
    parameter int NumOpsWidth  = 3,
    parameter int PermuteWidth = 7
) (
    input  logic [HVDimension-1:0]  acc,
    input  logic [HVDimension-1:0]  b,
    input  logic [NumOpsWidth-1:0]  op,
    input  logic [PermuteWidth-1:0] s,
    output logic [HVDimension-1:0]  result
);

    localparam int IdxW = $clog2(2 * HVDimension);

    // Rotates are taken as a window into acc concatenated with itself, so the
    // wrap-around needs no modulo arithmetic.
    logic [2*HVDimension-1:0] dbl;
    logic [IdxW-1:0]          ror_idx;
    logic [IdxW-1:0]          rol_idx;

    // Operation select; unknown codes fall back to XOR
    always_comb begin
        dbl     = {acc, acc};
        ror_idx = IdxW'(s);
        rol_idx = IdxW'(HVDimension) - IdxW'(s);
        case (32'(op))
            32'(HV_AND):   result = acc & b;
            32'(HV_OR):    result = acc | b;
            32'(HV_ROR):   result = dbl[ror_idx +: HVDimension];
            32'(HV_ROL):   result = dbl[rol_idx +: HVDimension];
            32'(HV_NOT):   result = ~acc;
            32'(HV_PASSA): result = acc;
            32'(HV_PASSB): result = b;
            default:       result = acc ^ b;
        endcase
    end

endmodule

// File: rtl/hv_alu_pe_iter.sv
// Iterative hypervector ALU PE: accepts one request, applies the selected
// operation N times with the result fed back as operand A, then presents the
// registered result until the consumer takes it.
// Optional build macro HV_ALU_PE_POPCOUNT_EN adds popcount_o, the number of
// ones in the final result, valid together with out_valid_o.
module hv_alu_pe_iter
    import hv_alu_pkg::*;
#(
    parameter int HVDimension  = HV_DIM_DEFAULT,
    parameter int NumOps       = NUM_OPS_DEFAULT,
    parameter int NumOpsWidth  = $clog2(NumOps),
    parameter int MaxShiftAmt  = MAX_SHIFT_DEFAULT,
    parameter int PermuteWidth = $clog2(MaxShiftAmt),
    parameter int MaxRepeat    = MAX_REPEAT_DEFAULT,
    parameter int RepeatWidth  = $clog2(MaxRepeat + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [HVDimension-1:0]  A_i,
    input  logic [HVDimension-1:0]  B_i,
    input  logic [NumOpsWidth-1:0]  op_i,
    input  logic [PermuteWidth-1:0] shift_amt_i,
    input  logic [RepeatWidth-1:0]  repeat_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [HVDimension-1:0]  C_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    busy_o
`ifdef HV_ALU_PE_POPCOUNT_EN
    ,
    output logic [$clog2(HVDimension+1)-1:0] popcount_o
`endif
);

    hv_state_e               state_reg, state_next;
    logic [HVDimension-1:0]  acc_reg;
    logic [HVDimension-1:0]  b_reg;
    logic [NumOpsWidth-1:0]  op_reg;
    logic [PermuteWidth-1:0] s_reg;
    logic [RepeatWidth-1:0]  cnt_reg;
    logic [HVDimension-1:0]  step_result;
    logic [PermuteWidth-1:0] s_next;
    logic [RepeatWidth-1:0]  cnt_next;
    logic                    load_en;
    logic                    step_en;
    logic                    last_step;

    assign last_step = (cnt_reg == RepeatWidth'(1));

    // Reduce the rotate amount once at accept time so the datapath sees s < D
    assign s_next   = PermuteWidth'(32'(shift_amt_i) % HVDimension);
    // A repeat count of zero still performs one iteration
    assign cnt_next = (repeat_i == '0) ? RepeatWidth'(1) : repeat_i;

    hv_alu_step #(
        .HVDimension (HVDimension),
        .NumOpsWidth (NumOpsWidth),
        .PermuteWidth(PermuteWidth)
    ) u_step (
        .acc   (acc_reg),
        .b     (b_reg),
        .op    (op_reg),
        .s     (s_reg),
        .result(step_result)
    );

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_next  = state_reg;
        in_ready_o  = 1'b0;
        busy_o      = 1'b0;
        out_valid_o = 1'b0;
        load_en     = 1'b0;
        step_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    load_en    = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy_o  = 1'b1;
                step_en = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture at accept, then one iteration per BUSY cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_reg <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            s_reg   <= '0;
            cnt_reg <= '0;
        end else if (load_en) begin
            acc_reg <= A_i;
            b_reg   <= B_i;
            op_reg  <= op_i;
            s_reg   <= s_next;
            cnt_reg <= cnt_next;
        end else if (step_en) begin
            acc_reg <= step_result;
            cnt_reg <= cnt_reg - RepeatWidth'(1);
        end
    end

    assign C_o = acc_reg;

`ifdef HV_ALU_PE_POPCOUNT_EN
    localparam int PopW = $clog2(HVDimension + 1);

    logic [PopW-1:0] pop_next;
    logic [PopW-1:0] pop_reg;

    // Ones count of the value about to become the final result
    always_comb begin
        pop_next = '0;
        for (int i = 0; i < HVDimension; i++) begin
            pop_next = pop_next + PopW'(step_result[i]);
        end
    end

    // Capture the count on the BUSY->DONE transition only
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pop_reg <= '0;
        end else if (step_en && last_step) begin
            pop_reg <= pop_next;
        end
    end

    assign popcount_o = pop_reg;
`endif

endmodule

// File: tb/tb_hv_alu_pe_iter.sv
// Scoreboard bench for hv_alu_pe_iter at HVDimension=16.
module tb_hv_alu_pe_iter;

    localparam int D  = 16;
    localparam int OW = 3;
    localparam int PW = 7;
    localparam int RW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [D-1:0]  A_i;
    logic [D-1:0]  B_i;
    logic [OW-1:0] op_i;
    logic [PW-1:0] shift_amt_i;
    logic [RW-1:0] repeat_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [D-1:0]  C_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          busy_o;
`ifdef HV_ALU_PE_POPCOUNT_EN
    logic [$clog2(D+1)-1:0] popcount_o;
`endif

    hv_alu_pe_iter #(.HVDimension(D)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .A_i        (A_i),
        .B_i        (B_i),
        .op_i       (op_i),
        .shift_amt_i(shift_amt_i),
        .repeat_i   (repeat_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .C_o        (C_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .busy_o     (busy_o)
`ifdef HV_ALU_PE_POPCOUNT_EN
        ,
        .popcount_o (popcount_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int txn_out = 0;
    int txn_exp = 0;

    typedef struct {
        logic [D-1:0] c;
        int           id;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model written from the bit-index definitions of each op
    function automatic logic [D-1:0] model(input int op, input logic [D-1:0] a,
                                           input logic [D-1:0] b, input int sh, input int rep);
        logic [D-1:0] acc;
        logic [D-1:0] nx;
        int n;
        int s;
        acc = a;
        n = (rep == 0) ? 1 : rep;
        s = sh % D;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < D; i++) begin
                case (op)
                    1: nx[i] = acc[i] & b[i];
                    2: nx[i] = acc[i] | b[i];
                    3: nx[i] = acc[(i + s) % D];
                    4: nx[i] = acc[(i - s + D) % D];
                    5: nx[i] = ~acc[i];
                    6: nx[i] = acc[i];
                    7: nx[i] = b[i];
                    default: nx[i] = acc[i] ^ b[i];
                endcase
            end
            acc = nx;
        end
        return acc;
    endfunction

    // Output monitor: pop and compare on every completed output handshake
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            txn_out++;
            if (sb_q.size() == 0) begin
                chk("unexpected_out", out_valid_o, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("txn %0d: C_o=%h exp=%h", e.id, C_o, e.c);
                chk("C_o", C_o, e.c);
`ifdef HV_ALU_PE_POPCOUNT_EN
                chk("popcount", popcount_o, $countones(e.c));
`endif
            end
        end
    end

    // Drive one request, check latency and handshake, optionally hold backpressure
    task automatic send(input int op, input logic [D-1:0] a, input logic [D-1:0] b,
                        input int sh, input int rep, input int bp);
        exp_t e;
        int k;
        int n;
        n = (rep == 0) ? 1 : rep;
        e.c = model(op, a, b, sh, rep);
        e.id = txn_exp;
        txn_exp++;
        sb_q.push_back(e);
        chk("in_ready_pre", in_ready_o, 1);
        out_ready_i = (bp == 0);
        A_i = a; B_i = b; op_i = OW'(op); shift_amt_i = PW'(sh); repeat_i = RW'(rep);
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        // keep a junk request pending while the PE is busy; it must be ignored
        A_i = D'($urandom); B_i = D'($urandom); op_i = OW'($urandom);
        k = 1;
        chk("busy", busy_o, 1);
        chk("in_ready_busy", in_ready_o, 0);
        while (!out_valid_o && k < 40) begin
            @(posedge clk_i); #1;
            k++;
        end
        in_valid_i = 1'b0;
        chk("latency", k, n + 1);
        for (int j = 0; j < bp; j++) begin
            @(posedge clk_i); #1;
            chk("bp_valid", out_valid_o, 1);
            chk("bp_C", C_o, e.c);
            chk("bp_in_ready", in_ready_o, 0);
        end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("post_valid", out_valid_o, 0);
        chk("post_in_ready", in_ready_o, 1);
    endtask

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
        A_i = '0; B_i = '0; op_i = '0; shift_amt_i = '0; repeat_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_C", C_o, 0);
`ifdef HV_ALU_PE_POPCOUNT_EN
        chk("rst_pop", popcount_o, 0);
`endif
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        send(0, 16'h00FF, 16'h0F0F, 0, 1, 0);
        send(3, 16'h0001, 16'h0000, 1, 4, 0);
        send(3, 16'h0001, 16'h0000, 0, 4, 0);
        send(4, 16'h8001, 16'h0000, 3, 0, 0);
        send(5, 16'hA5C3, 16'h0000, 0, 2, 0);
        send(3, 16'h8421, 16'h1234, 17, 15, 0);
        send(4, 16'h0F01, 16'h0000, 127, 3, 0);
        send(7, 16'h1111, 16'hBEEF, 0, 2, 0);
        send(6, 16'hCAFE, 16'hFFFF, 0, 5, 0);
        for (int t = 0; t < 8; t++) begin
            send(int'($urandom_range(0, 7)), D'($urandom), D'($urandom),
                 int'($urandom_range(0, 127)), int'($urandom_range(0, 15)), 0);
        end
        send(2, 16'h0F00, 16'h00F0, 0, 1, 10);

        // Reset in the second BUSY cycle of an 8-iteration request
        A_i = 16'h1234; B_i = 16'h5678; op_i = 3'd0; shift_amt_i = '0; repeat_i = 4'd8;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("midrst_valid", out_valid_o, 0);
        chk("midrst_C", C_o, 0);
        chk("midrst_in_ready", in_ready_o, 1);
        chk("midrst_busy", busy_o, 0);
        repeat (15) @(posedge clk_i);
        #1;

        chk("outputs_seen", txn_out, txn_exp);
        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
